pong_scoreboard: RTL and testbench
==================================

Name: pong_scoreboard

Overview:
- Parametrised multi-player, multi-digit BCD scoreboard for the pong top level; successor to the single-digit fixed score display.
- Counts point pulses per player and holds play for a fixed pause after each point.
- Detects the winner and freezes the game on a win.
- Emits registered 5x7 glyph bitmaps (35 bits per digit) for the VGA sprite renderer.

Parameters:
- PLAYERS, 2, number of score channels (1..4).
- DIGITS, 2, BCD digits per channel (1..3).
- WIN_SCORE, 11, score that ends the game (1..10^DIGITS-1).
- HOLD_CYCLES, 100_000_000, pause length after a point, in clk cycles (≥1).
- GLYPH_W, 35, bits per digit glyph (5 columns x 7 rows).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- point  in  PLAYERS  one-cycle pulse; bit i scores a point for player i
- new_game  in  1  synchronous clear of all scores, returns to PLAY
- score_bcd  out  PLAYERS*DIGITS*4  BCD scores; player i occupies bits [i*DIGITS*4 +: DIGITS*4], with the LS digit lowest
- glyphs  out  PLAYERS*DIGITS*GLYPH_W  glyph per digit, same ordering as score_bcd
- serve  out  1  one-cycle pulse when the ball may be released
- playing  out  1  high in PLAY
- game_over  out  1  high in OVER
- winner  out  PLAYERS  one-hot winner, valid while game_over

Behaviour:
- Reset (rst=0, async):
  - All scores 0; glyphs register the glyph for "0"; state = PLAY.
  - serve=0, playing=1 after reset release, game_over=0, winner=0, hold counter 0.
- States:
  - PLAY: accepts points.
    - If any point bit is set, credit only the lowest-index asserted player; other simultaneous bits are dropped.
    - Score increments in BCD with carry across digits.
    - Updated score is visible the cycle after the pulse (latency 1).
    - Next state is OVER if the win condition is met, otherwise HOLD.
  - HOLD: point input ignored.
    - Counter runs 0..HOLD_CYCLES-1.
    - At terminal count: go to PLAY and pulse serve for exactly 1 cycle, coincident with the first PLAY cycle.
  - OVER: point input ignored.
    - winner holds the one-hot index of the scoring player; scores frozen.
- new_game:
  - Takes effect in any state on the next edge: scores cleared, winner cleared, counter cleared, state=PLAY, serve pulses 1 cycle.
  - Has priority over a point in the same cycle; that point is lost.
- Win condition: the credited player's new score ≥ WIN_SCORE.
- Saturation: a score at 10^DIGITS-1 does not wrap; increments are discarded.
- glyphs:
  - Registered; lag score_bcd by 1 cycle (latency 2 from the point pulse).
  - BCD codes 10..15 produce an all-zero glyph.
- Hold counter width: $clog2(HOLD_CYCLES+1); no other arithmetic wider than 4 bits per digit.
- Reset asserted mid-HOLD or mid-OVER aborts immediately to the reset values.

Optional Feature:
- WIN_BY_TWO_EN
- Defined: the win additionally requires the scorer's new score ≥ every other player's score + 2 (deuce play).
  - Otherwise go to HOLD and keep playing.
  - At saturation with no 2-point lead, the game stays in PLAY/HOLD indefinitely; new_game is required.
- Undefined: plain ≥ WIN_SCORE rule.

Decomposition:
- Package pong_pkg:
  - state encoding (PLAY, HOLD, OVER)
  - GLYPH_W
  - the ten 35-bit digit bitmap constants
  - BCD digit width (4)
- Sub-module pong_glyph_rom: combinational 4-bit BCD to 35-bit glyph; one instance per digit via generate.
- The top module contains the FSM, the BCD counters and the output registers.

Test Plan:
- Reset: rst=0 mid-simulation -> all score_bcd=0, glyphs=glyph "0", serve=0, game_over=0, playing=1 after release.
- Single point (HOLD_CYCLES=4): point=2'b01 at cycle n -> player0 score 01 at n+1, glyph "1" at n+2, playing=0 for 4 cycles, serve pulse 1 cycle at n+5.
- Carry and priority:
  - 10 spaced points to player0 -> score_bcd digits 1,0.
  - point=2'b11 -> only player0 credited (11); player1 unchanged.
- Win (WIN_SCORE=11): player0 at 10, point=2'b01 -> game_over=1, winner=2'b01, no serve.
  - Further points ignored.
  - new_game -> scores 0, serve pulse, playing=1.
- Saturation: DIGITS=1, WIN_SCORE=9 with WIN_BY_TWO_EN, players tied at 8 -> 9-8 does not win; score at 9 stays 9 on further points.
- new_game collision: new_game and point=2'b10 in the same cycle during HOLD -> all scores 0, player1 not credited.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong scoreboard.
// FSM encoding, BCD digit width and the 5x7 digit font.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int BCD_W   = 4;
  localparam int GLYPH_W = 35;

  // Row-major, top row in the MSBs, leftmost column first.
  localparam logic [GLYPH_W-1:0] GLYPH_0 =
    35'b01110_10001_10011_10101_11001_10001_01110;
  localparam logic [GLYPH_W-1:0] GLYPH_1 =
    35'b00100_01100_00100_00100_00100_00100_01110;
  localparam logic [GLYPH_W-1:0] GLYPH_2 =
    35'b01110_10001_00001_00010_00100_01000_11111;
  localparam logic [GLYPH_W-1:0] GLYPH_3 =
    35'b11111_00010_00100_00010_00001_10001_01110;
  localparam logic [GLYPH_W-1:0] GLYPH_4 =
    35'b00010_00110_01010_10010_11111_00010_00010;
  localparam logic [GLYPH_W-1:0] GLYPH_5 =
    35'b11111_10000_11110_00001_00001_10001_01110;
  localparam logic [GLYPH_W-1:0] GLYPH_6 =
    35'b00110_01000_10000_11110_10001_10001_01110;
  localparam logic [GLYPH_W-1:0] GLYPH_7 =
    35'b11111_00001_00010_00100_01000_01000_01000;
  localparam logic [GLYPH_W-1:0] GLYPH_8 =
    35'b01110_10001_10001_01110_10001_10001_01110;
  localparam logic [GLYPH_W-1:0] GLYPH_9 =
    35'b01110_10001_10001_01111_00001_00010_01100;

endpackage

// File: rtl/pong_glyph_rom.sv
// Combinational BCD digit to 5x7 glyph lookup.
// Non-decimal codes map to a blank glyph.
module pong_glyph_rom
  import pong_pkg::*;
(
  input  logic [BCD_W-1:0]   digit,
  output logic [GLYPH_W-1:0] glyph
);

  always_comb begin
    unique case (digit)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = '0;
    endcase
  end

endmodule

// File: rtl/pong_scoreboard.sv
// Multi-player BCD scoreboard with post-point hold and win detect.
// Define WIN_BY_TWO_EN to require a two-point lead for the win.
module pong_scoreboard #(
  parameter int PLAYERS     = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 11,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GLYPH_W     = pong_pkg::GLYPH_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PLAYERS-1:0]            point,
  input  logic                          new_game,
  output logic [PLAYERS*DIGITS*4-1:0]   score_bcd,
  output logic [PLAYERS*DIGITS*GLYPH_W-1:0] glyphs,
  output logic                          serve,
  output logic                          playing,
  output logic                          game_over,
  output logic [PLAYERS-1:0]            winner
);
  import pong_pkg::*;

  localparam int SW = DIGITS * BCD_W;
  localparam int NG = PLAYERS * DIGITS;
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef logic [SW-1:0] score_t;

  function automatic score_t to_bcd(input int v);
    score_t r;
    int     x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Ripple increment; the top bit flags a carry out of all-nines.
  function automatic logic [SW:0] bcd_inc(input score_t s);
    score_t r;
    logic   c;
    r = s;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (s[d*4 +: 4] >= 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = s[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  localparam score_t WIN_BCD = to_bcd(WIN_SCORE);

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  score_t              score [PLAYERS];
  score_t              score_nx [PLAYERS];
  logic [PLAYERS-1:0]  winner_nx;
  logic                serve_nx;
  logic [PLAYERS-1:0]  hot;
  score_t              cur, inc, nxt;
  logic                ovf, win;
  logic [NG*GLYPH_W-1:0] glyph_nx;

  always_comb begin
    logic found;
`ifdef WIN_BY_TWO_EN
    logic [SW:0] oth;
`endif
    found = 1'b0;
    hot   = '0;
    cur   = '0;
    for (int i = 0; i < PLAYERS; i++) begin
      if (point[i] && !found) begin
        hot[i] = 1'b1;
        found  = 1'b1;
        cur    = score[i];
      end
    end
    {ovf, inc} = bcd_inc(cur);
    nxt = ovf ? cur : inc;
    win = (nxt >= WIN_BCD);
`ifdef WIN_BY_TWO_EN
    // new >= other + 2 is checked as new > other + 1.
    for (int i = 0; i < PLAYERS; i++) begin
      oth = bcd_inc(score[i]);
      if (!hot[i] && (oth[SW] || !(nxt > oth[SW-1:0])))
        win = 1'b0;
    end
`endif
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    score_nx  = score;
    winner_nx = winner;
    serve_nx  = 1'b0;
    unique case (state)
      ST_PLAY: begin
        if (|point) begin
          for (int i = 0; i < PLAYERS; i++)
            if (hot[i]) score_nx[i] = nxt;
          if (win) begin
            state_nx  = ST_OVER;
            winner_nx = hot;
          end else begin
            state_nx = ST_HOLD;
            cnt_nx   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = ST_PLAY;
          cnt_nx   = '0;
          serve_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_OVER: ;
      default: state_nx = ST_PLAY;
    endcase
    if (new_game) begin
      score_nx  = '{default: '0};
      winner_nx = '0;
      cnt_nx    = '0;
      state_nx  = ST_PLAY;
      serve_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_PLAY;
      cnt    <= '0;
      score  <= '{default: '0};
      winner <= '0;
      serve  <= 1'b0;
      glyphs <= {NG{GLYPH_0}};
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      score  <= score_nx;
      winner <= winner_nx;
      serve  <= serve_nx;
      glyphs <= glyph_nx;
    end
  end

  for (genvar i = 0; i < PLAYERS; i++) begin : g_pack
    assign score_bcd[i*SW +: SW] = score[i];
  end

  for (genvar g = 0; g < NG; g++) begin : g_rom
    pong_glyph_rom u_rom (
      .digit (score_bcd[g*4 +: 4]),
      .glyph (glyph_nx[g*GLYPH_W +: GLYPH_W])
    );
  end

  assign playing   = (state == ST_PLAY);
  assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_pong_scoreboard.sv
// Bench for pong_scoreboard: directed scenarios plus random play
// against an integer-level reference model of two configurations.
module tb_pong_scoreboard;

  localparam int M_PLAY = 0;
  localparam int M_HOLD = 1;
  localparam int M_OVER = 2;
`ifdef WIN_BY_TWO_EN
  localparam bit WB2 = 1'b1;
`else
  localparam bit WB2 = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   point_a = '0, point_b = '0;
  logic         new_game_a = 1'b0, new_game_b = 1'b0;
  logic [15:0]  score_a;
  logic [7:0]   score_b;
  logic [139:0] glyphs_a;
  logic [69:0]  glyphs_b;
  logic         serve_a, serve_b, playing_a, playing_b;
  logic         game_over_a, game_over_b;
  logic [1:0]   winner_a, winner_b;

  int checks = 0;
  int passed = 0;

  int ms [2][2];
  int mprev [2][2];
  int mmode [2];
  int mrem [2];
  int mwin [2];
  bit mserve [2];

  always #5 clk = ~clk;

  pong_scoreboard #(
    .PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .HOLD_CYCLES(4)
  ) dut_a (
    .clk(clk), .rst(rst), .point(point_a), .new_game(new_game_a),
    .score_bcd(score_a), .glyphs(glyphs_a), .serve(serve_a),
    .playing(playing_a), .game_over(game_over_a), .winner(winner_a)
  );

  pong_scoreboard #(
    .PLAYERS(2), .DIGITS(1), .WIN_SCORE(9), .HOLD_CYCLES(2)
  ) dut_b (
    .clk(clk), .rst(rst), .point(point_b), .new_game(new_game_b),
    .score_bcd(score_b), .glyphs(glyphs_b), .serve(serve_b),
    .playing(playing_b), .game_over(game_over_b), .winner(winner_b)
  );

  function automatic int maxs(int k);  return k ? 9 : 99; endfunction
  function automatic int wins(int k);  return k ? 9 : 11; endfunction
  function automatic int holds(int k); return k ? 2 : 4;  endfunction
  function automatic int ndig(int k);  return k ? 1 : 2;  endfunction

  function automatic logic [34:0] font(int d);
    case (d)
      0: return 35'b01110_10001_10011_10101_11001_10001_01110;
      1: return 35'b00100_01100_00100_00100_00100_00100_01110;
      2: return 35'b01110_10001_00001_00010_00100_01000_11111;
      3: return 35'b11111_00010_00100_00010_00001_10001_01110;
      4: return 35'b00010_00110_01010_10010_11111_00010_00010;
      5: return 35'b11111_10000_11110_00001_00001_10001_01110;
      6: return 35'b00110_01000_10000_11110_10001_10001_01110;
      7: return 35'b11111_00001_00010_00100_01000_01000_01000;
      8: return 35'b01110_10001_10001_01110_10001_10001_01110;
      9: return 35'b01110_10001_10001_01111_00001_00010_01100;
      default: return '0;
    endcase
  endfunction

  function automatic logic [15:0] exp_bcd(int k);
    logic [15:0] r;
    int p10;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      p10 = 1;
      for (int d = 0; d < ndig(k); d++) begin
        r[(i*ndig(k)+d)*4 +: 4] = 4'((ms[k][i] / p10) % 10);
        p10 = p10 * 10;
      end
    end
    return r;
  endfunction

  function automatic logic [139:0] exp_glyph(int k);
    logic [139:0] r;
    int p10;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      p10 = 1;
      for (int d = 0; d < ndig(k); d++) begin
        r[(i*ndig(k)+d)*35 +: 35] = font((mprev[k][i] / p10) % 10);
        p10 = p10 * 10;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        ms[k][i] = 0;
        mprev[k][i] = 0;
      end
      mmode[k] = M_PLAY;
      mrem[k] = 0;
      mwin[k] = 0;
      mserve[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k, logic [1:0] p, logic ng);
    int w, s;
    for (int i = 0; i < 2; i++) mprev[k][i] = ms[k][i];
    mserve[k] = 1'b0;
    if (ng) begin
      ms[k][0] = 0;
      ms[k][1] = 0;
      mmode[k] = M_PLAY;
      mwin[k] = 0;
      mserve[k] = 1'b1;
    end else if (mmode[k] == M_PLAY) begin
      if (p != 2'b00) begin
        w = p[0] ? 0 : 1;
        s = ms[k][w] + 1;
        if (s > maxs(k)) s = maxs(k);
        ms[k][w] = s;
        if (s >= wins(k) && (!WB2 || s >= ms[k][1-w] + 2)) begin
          mmode[k] = M_OVER;
          mwin[k] = 1 << w;
        end else begin
          mmode[k] = M_HOLD;
          mrem[k] = holds(k);
        end
      end
    end else if (mmode[k] == M_HOLD) begin
      mrem[k]--;
      if (mrem[k] == 0) begin
        mmode[k] = M_PLAY;
        mserve[k] = 1'b1;
      end
    end
  endtask

  task automatic tick(logic [1:0] pa, logic nga,
                      logic [1:0] pb, logic ngb);
    point_a = pa;
    new_game_a = nga;
    point_b = pb;
    new_game_b = ngb;
    @(posedge clk);
    model_step(0, pa, nga);
    model_step(1, pb, ngb);
    #1;
    point_a = '0;
    new_game_a = 1'b0;
    point_b = '0;
    new_game_b = 1'b0;
  endtask

  task automatic point_wait_a(logic [1:0] p);
    tick(p, 1'b0, 2'b00, 1'b0);
    repeat (4) tick(2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic point_wait_b(logic [1:0] p);
    tick(2'b00, 1'b0, p, 1'b0);
    repeat (2) tick(2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if (score_a !== 16'h0000 || glyphs_a !== exp_glyph(0))
      $display("FAIL reset_a: score %h glyph %h, required 0000 %h",
               score_a, glyphs_a, exp_glyph(0));
    else passed++;
    checks++;
    if (serve_a !== 1'b0 || game_over_a !== 1'b0 || winner_a !== 2'b00)
      $display("FAIL reset_a_flags: serve %b over %b win %b, required 0 0 00",
               serve_a, game_over_a, winner_a);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    tick(2'b00, 1'b0, 2'b00, 1'b0);
    checks++;
    if (playing_a !== 1'b1 || playing_b !== 1'b1 || serve_a !== 1'b0)
      $display("FAIL reset_release: playing %b/%b serve %b, required 1/1 0",
               playing_a, playing_b, serve_a);
    else passed++;
  endtask

  task automatic test_single_point();
    tick(2'b01, 1'b0, 2'b00, 1'b0);
    checks++;
    if (score_a !== 16'h0001 || playing_a !== 1'b0 ||
        glyphs_a[34:0] !== font(0))
      $display("FAIL single_n1: score %h playing %b glyph %h, required 0001 0 %h",
               score_a, playing_a, glyphs_a[34:0], font(0));
    else passed++;
    for (int t = 2; t <= 6; t++) begin
      tick(2'b00, 1'b0, 2'b00, 1'b0);
      checks++;
      if (playing_a !== (t == 5 || t == 6) || serve_a !== (t == 5))
        $display("FAIL single_hold t%0d: playing %b serve %b, required %b %b",
                 t, playing_a, serve_a, (t == 5 || t == 6), (t == 5));
      else passed++;
      if (t == 2) begin
        checks++;
        if (glyphs_a[34:0] !== font(1))
          $display("FAIL single_glyph: got %h, required %h",
                   glyphs_a[34:0], font(1));
        else passed++;
      end
    end
  endtask

  task automatic test_carry_win();
    tick(2'b00, 1'b1, 2'b00, 1'b0);
    checks++;
    if (score_a !== 16'h0000 || serve_a !== 1'b1)
      $display("FAIL ng_clear: score %h serve %b, required 0000 1",
               score_a, serve_a);
    else passed++;
    repeat (10) point_wait_a(2'b01);
    checks++;
    if (score_a !== 16'h0010 || playing_a !== 1'b1)
      $display("FAIL carry: score %h playing %b, required 0010 1",
               score_a, playing_a);
    else passed++;
    tick(2'b11, 1'b0, 2'b00, 1'b0);
    checks++;
    if (score_a !== 16'h0011 || game_over_a !== 1'b1 ||
        winner_a !== 2'b01 || serve_a !== 1'b0)
      $display("FAIL prio_win: score %h over %b win %b serve %b, required 0011 1 01 0",
               score_a, game_over_a, winner_a, serve_a);
    else passed++;
    for (int t = 0; t < 6; t++) begin
      tick(2'($urandom_range(1, 3)), 1'b0, 2'b00, 1'b0);
      checks++;
      if (score_a !== 16'h0011 || serve_a !== 1'b0 ||
          game_over_a !== 1'b1 || winner_a !== 2'b01)
        $display("FAIL over_frozen t%0d: score %h serve %b over %b win %b",
                 t, score_a, serve_a, game_over_a, winner_a);
      else passed++;
    end
    tick(2'b00, 1'b1, 2'b00, 1'b0);
    checks++;
    if (score_a !== 16'h0000 || serve_a !== 1'b1 || playing_a !== 1'b1 ||
        game_over_a !== 1'b0 || winner_a !== 2'b00)
      $display("FAIL new_game: score %h serve %b play %b over %b win %b, required 0000 1 1 0 00",
               score_a, serve_a, playing_a, game_over_a, winner_a);
    else passed++;
  endtask

  task automatic test_collision();
    tick(2'b10, 1'b0, 2'b00, 1'b0);
    checks++;
    if (score_a !== 16'h0100 || playing_a !== 1'b0)
      $display("FAIL coll_setup: score %h playing %b, required 0100 0",
               score_a, playing_a);
    else passed++;
    tick(2'b10, 1'b1, 2'b00, 1'b0);
    checks++;
    if (score_a !== 16'h0000 || serve_a !== 1'b1 || playing_a !== 1'b1)
      $display("FAIL coll_hold: score %h serve %b play %b, required 0000 1 1",
               score_a, serve_a, playing_a);
    else passed++;
    tick(2'b10, 1'b1, 2'b00, 1'b0);
    checks++;
    if (score_a !== 16'h0000 || serve_a !== 1'b1 || playing_a !== 1'b1)
      $display("FAIL coll_play: score %h serve %b play %b, required 0000 1 1",
               score_a, serve_a, playing_a);
    else passed++;
  endtask

  task automatic test_saturation();
    tick(2'b00, 1'b0, 2'b00, 1'b1);
    for (int r = 0; r < 8; r++) begin
      point_wait_b(2'b01);
      point_wait_b(2'b10);
    end
    checks++;
    if (score_b !== 8'h88 || game_over_b !== 1'b0)
      $display("FAIL sat_tie: score %h over %b, required 88 0",
               score_b, game_over_b);
    else passed++;
    point_wait_b(2'b01);
    point_wait_b(2'b01);
    checks++;
    if (score_b !== 8'h89 || game_over_b !== !WB2 ||
        winner_b !== (WB2 ? 2'b00 : 2'b01))
      $display("FAIL sat_top: score %h over %b win %b, required 89 %b %b",
               score_b, game_over_b, winner_b, !WB2,
               (WB2 ? 2'b00 : 2'b01));
    else passed++;
  endtask

  task automatic test_reset_mid();
    tick(2'b01, 1'b0, 2'b00, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (score_a !== 16'h0000 || score_b !== 8'h00 ||
        glyphs_a !== exp_glyph(0) || serve_a !== 1'b0 ||
        playing_a !== 1'b1 || game_over_b !== 1'b0 || winner_b !== 2'b00)
      $display("FAIL reset_mid: score %h/%h play %b over_b %b win_b %b, required 0000/00 1 0 00",
               score_a, score_b, playing_a, game_over_b, winner_b);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    tick(2'b00, 1'b0, 2'b00, 1'b0);
    checks++;
    if (playing_a !== 1'b1 || serve_a !== 1'b0 || score_a !== 16'h0000)
      $display("FAIL reset_mid_rel: play %b serve %b score %h, required 1 0 0000",
               playing_a, serve_a, score_a);
    else passed++;
  endtask

  task automatic test_random();
    logic [1:0] pa, pb;
    logic nga, ngb;
    for (int c = 0; c < 600; c++) begin
      pa  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      pb  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      nga = ($urandom_range(0, 59) == 0);
      ngb = ($urandom_range(0, 49) == 0);
      tick(pa, nga, pb, ngb);
      checks++;
      if (score_a !== exp_bcd(0) || glyphs_a !== exp_glyph(0) ||
          serve_a !== mserve[0] || playing_a !== (mmode[0] == M_PLAY) ||
          game_over_a !== (mmode[0] == M_OVER) || winner_a !== 2'(mwin[0]))
        $display("FAIL rand_a c%0d: score %h serve %b play %b over %b win %b glyph %h, required %h %b %b %b %b %h",
                 c, score_a, serve_a, playing_a, game_over_a, winner_a,
                 glyphs_a, exp_bcd(0), mserve[0], (mmode[0] == M_PLAY),
                 (mmode[0] == M_OVER), 2'(mwin[0]), exp_glyph(0));
      else passed++;
      checks++;
      if ({8'h00, score_b} !== exp_bcd(1) ||
          {70'b0, glyphs_b} !== exp_glyph(1) ||
          serve_b !== mserve[1] || playing_b !== (mmode[1] == M_PLAY) ||
          game_over_b !== (mmode[1] == M_OVER) || winner_b !== 2'(mwin[1]))
        $display("FAIL rand_b c%0d: score %h serve %b play %b over %b win %b, required %h %b %b %b %b",
                 c, score_b, serve_b, playing_b, game_over_b, winner_b,
                 exp_bcd(1), mserve[1], (mmode[1] == M_PLAY),
                 (mmode[1] == M_OVER), 2'(mwin[1]));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_carry_win();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
